// File: rtl/aes_stream_arb.sv
// ---------------------------------------------------------------------------
// aes_stream_arb
//
// Packet-level arbiter that merges the two AES result byte streams into the
// single byte stream feeding the UART transmit path.
//   channel 0 (s0_axis_*) : results from the invcipher path
//   channel 1 (s1_axis_*) : results from the cipher path (and others)
//
// A channel that wins arbitration keeps the grant until its tlast beat has
// been accepted. Bytes from different packets therefore never interleave.
// The merged stream passes through one output register stage.
//
// Configuration macro:
//   AES_ARB_RR_EN  defined     -> round-robin on a tie. The channel that did
//                                 not own the previous packet wins.
//                  not defined -> fixed priority. s0 wins every tie.
//                                 last_owner is still tracked but not used.
//
// Parameters:
//   CNT_W   width of the per-channel completed-packet counters
//   DATA_W  width of tdata (bytes for the UART path)
//
// Ports:
//   clk               single clock, rising edge
//   rst_n             synchronous active-low reset
//   s0_axis_tdata/tvalid/tlast (in), s0_axis_tready (out)   channel 0 slave
//   s1_axis_tdata/tvalid/tlast (in), s1_axis_tready (out)   channel 1 slave
//   m_axis_tdata/tvalid/tlast (out), m_axis_tready (in)     merged master
//   idle      high when no packet is locked and the output register is empty
//   grant     one-hot owner (bit0 = s0, bit1 = s1), 2'b00 while in IDLE
//   pkt_cnt0  saturating count of packets fully forwarded from s0
//   pkt_cnt1  saturating count of packets fully forwarded from s1
//   cnt_clr   synchronous clear of both counters (wins over an increment)
// ---------------------------------------------------------------------------
module aes_stream_arb #(
    parameter int CNT_W  = 16,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic [DATA_W-1:0] s0_axis_tdata,
    input  logic              s0_axis_tvalid,
    input  logic              s0_axis_tlast,
    output logic              s0_axis_tready,

    input  logic [DATA_W-1:0] s1_axis_tdata,
    input  logic              s1_axis_tvalid,
    input  logic              s1_axis_tlast,
    output logic              s1_axis_tready,

    output logic [DATA_W-1:0] m_axis_tdata,
    output logic              m_axis_tvalid,
    output logic              m_axis_tlast,
    input  logic              m_axis_tready,

    output logic              idle,
    output logic [1:0]        grant,
    output logic [CNT_W-1:0]  pkt_cnt0,
    output logic [CNT_W-1:0]  pkt_cnt1,
    input  logic              cnt_clr
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARB  = 2'd1,
        ST_LOCK = 2'd2
    } state_e;

    localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);
    localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

    state_e state_q, state_d;

    // Owner encoding: 0 = s0, 1 = s1.
    logic owner_q, owner_d;
    logic lastOwner_q, lastOwner_d;

    logic              mValid_q;
    logic              mLast_q;
    logic [DATA_W-1:0] mData_q;

    logic [CNT_W-1:0]  cnt0_q;
    logic [CNT_W-1:0]  cnt1_q;

    logic              anyValid;
    logic              tieWinner;
    logic              arbPick;
    logic              ownerValid;
    logic              ownerLast;
    logic [DATA_W-1:0] ownerData;
    logic              ownerReady;
    logic              accept;
    logic              pktDone;

    // Tie-break selection. Only this assignment differs between the two
    // arbitration policies; everything else is shared.
`ifdef AES_ARB_RR_EN
    assign tieWinner = ~lastOwner_q;
`else
    assign tieWinner = 1'b0;
`endif

    // With a single requester that requester wins; a tie goes to tieWinner.
    assign anyValid = s0_axis_tvalid | s1_axis_tvalid;
    assign arbPick  = (s0_axis_tvalid & s1_axis_tvalid) ? tieWinner : s1_axis_tvalid;

    // Owner-side view of the input streams. The non-owner's data never
    // reaches the output register because every load is qualified by accept.
    assign ownerValid = owner_q ? s1_axis_tvalid : s0_axis_tvalid;
    assign ownerLast  = owner_q ? s1_axis_tlast  : s0_axis_tlast;
    assign ownerData  = owner_q ? s1_axis_tdata  : s0_axis_tdata;

    // The output register can take a beat when it is empty or draining this
    // cycle. This is the only combinational use of m_axis_tready.
    assign ownerReady = (state_q == ST_LOCK) && (!mValid_q || m_axis_tready);
    assign accept     = ownerValid && ownerReady;
    assign pktDone    = accept && ownerLast;

    // -----------------------------------------------------------------------
    // State register: FSM state, the registered owner decision and the
    // owner of the most recently completed packet.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            owner_q     <= 1'b0;
            lastOwner_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            lastOwner_q <= lastOwner_d;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic. The owner is captured on the IDLE->ARB transition
    // and held until the owner's tlast beat is accepted in LOCK.
    // -----------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        lastOwner_d = lastOwner_q;
        case (state_q)
            ST_IDLE: begin
                if (anyValid) begin
                    state_d = ST_ARB;
                    owner_d = arbPick;
                end
            end
            ST_ARB: begin
                state_d = ST_LOCK;
            end
            ST_LOCK: begin
                if (pktDone) begin
                    state_d     = ST_IDLE;
                    lastOwner_d = owner_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Output decodes. grant and idle depend only on registered state, so no
    // input tvalid can reach them combinationally.
    // -----------------------------------------------------------------------
    always_comb begin
        s0_axis_tready = ownerReady && !owner_q;
        s1_axis_tready = ownerReady &&  owner_q;
        grant          = 2'b00;
        if (state_q != ST_IDLE) begin
            grant = owner_q ? 2'b10 : 2'b01;
        end
        idle = (state_q == ST_IDLE) && !mValid_q;
    end

    // -----------------------------------------------------------------------
    // Output register. A new beat overrides the drain in the same cycle.
    // When nothing is loaded, tdata/tlast keep their value, so they stay
    // stable during a stall.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mValid_q <= 1'b0;
            mLast_q  <= 1'b0;
            mData_q  <= '0;
        end else if (accept) begin
            mValid_q <= 1'b1;
            mLast_q  <= ownerLast;
            mData_q  <= ownerData;
        end else if (m_axis_tready) begin
            mValid_q <= 1'b0;
        end
    end

    assign m_axis_tvalid = mValid_q;
    assign m_axis_tlast  = mLast_q;
    assign m_axis_tdata  = mData_q;

    // -----------------------------------------------------------------------
    // Completed-packet counters. A packet counts when its tlast beat enters
    // the output register. The counters saturate instead of wrapping, and a
    // clear wins over a simultaneous increment.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt0_q <= '0;
            cnt1_q <= '0;
        end else if (cnt_clr) begin
            cnt0_q <= '0;
            cnt1_q <= '0;
        end else if (pktDone) begin
            if (!owner_q && (cnt0_q != CntMax)) begin
                cnt0_q <= cnt0_q + CntOne;
            end
            if (owner_q && (cnt1_q != CntMax)) begin
                cnt1_q <= cnt1_q + CntOne;
            end
        end
    end

    assign pkt_cnt0 = cnt0_q;
    assign pkt_cnt1 = cnt1_q;

endmodule

// File: tb/tb_aes_stream_arb.sv
// ---------------------------------------------------------------------------
// tb_aes_stream_arb
//
// Self-checking bench for aes_stream_arb, built with CNT_W = 2 so that the
// counters can be driven into saturation quickly.
//
// Each send pushes its expected output beats ({tlast, tdata}) onto a
// scoreboard queue. A monitor pops the queue and compares it against every
// beat that leaves m_axis. The scenario tasks check timing, grant, idle,
// stall stability, lock integrity, reset and the counters.
// ---------------------------------------------------------------------------
module tb_aes_stream_arb;

    localparam int CNT_W = 2;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [7:0]       s0_tdata, s1_tdata, m_tdata;
    logic             s0_tvalid, s0_tlast, s0_tready;
    logic             s1_tvalid, s1_tlast, s1_tready;
    logic             m_tvalid, m_tlast, m_tready;
    logic             idle;
    logic [1:0]       grant;
    logic [CNT_W-1:0] pkt_cnt0, pkt_cnt1;
    logic             cnt_clr;

    int checkCount = 0;
    int passCount  = 0;

    logic [8:0] sbQ[$];

    aes_stream_arb #(.CNT_W(CNT_W), .DATA_W(8)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .s0_axis_tdata  (s0_tdata),
        .s0_axis_tvalid (s0_tvalid),
        .s0_axis_tlast  (s0_tlast),
        .s0_axis_tready (s0_tready),
        .s1_axis_tdata  (s1_tdata),
        .s1_axis_tvalid (s1_tvalid),
        .s1_axis_tlast  (s1_tlast),
        .s1_axis_tready (s1_tready),
        .m_axis_tdata   (m_tdata),
        .m_axis_tvalid  (m_tvalid),
        .m_axis_tlast   (m_tlast),
        .m_axis_tready  (m_tready),
        .idle           (idle),
        .grant          (grant),
        .pkt_cnt0       (pkt_cnt0),
        .pkt_cnt1       (pkt_cnt1),
        .cnt_clr        (cnt_clr)
    );

    always #5 clk = ~clk;

    // Watchdog so that the run always terminates on its own.
    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    // Scoreboard monitor: every beat accepted at the output is compared
    // against the oldest expected beat.
    always @(negedge clk) begin
        logic [8:0] exp;
        if (m_tvalid === 1'b1 && m_tready === 1'b1) begin
            checkCount++;
            if (sbQ.size() == 0) begin
                $display("[TB] FAIL out_beat: got tlast=%0b tdata=%02h, required no beat (queue empty)", m_tlast, m_tdata);
            end else begin
                exp = sbQ.pop_front();
                if ({m_tlast, m_tdata} !== exp) begin
                    $display("[TB] FAIL out_beat: got tlast=%0b tdata=%02h, required tlast=%0b tdata=%02h",
                             m_tlast, m_tdata, exp[8], exp[7:0]);
                end else begin
                    passCount++;
                end
            end
        end
    end

    task automatic dropValid(input int ch);
        if (ch == 0) begin
            s0_tvalid = 1'b0; s0_tlast = 1'b0; s0_tdata = 8'h00;
        end else begin
            s1_tvalid = 1'b0; s1_tlast = 1'b0; s1_tdata = 8'h00;
        end
    endtask

    // Sends one packet on channel ch. Must be called at posedge+1 and
    // returns at posedge+1 just after the tlast beat was accepted.
    task automatic sendPkt(input int ch, input logic [7:0] d [8], input int len, input bit push);
        bit rdy;
        int waitCnt;
        if (push) begin
            for (int i = 0; i < len; i++) sbQ.push_back({(i == len - 1), d[i]});
        end
        for (int i = 0; i < len; i++) begin
            if (ch == 0) begin
                s0_tdata = d[i]; s0_tlast = (i == len - 1); s0_tvalid = 1'b1;
            end else begin
                s1_tdata = d[i]; s1_tlast = (i == len - 1); s1_tvalid = 1'b1;
            end
            waitCnt = 0;
            rdy     = 1'b0;
            while (!rdy) begin
                @(negedge clk);
                rdy = (ch == 0) ? (s0_tready === 1'b1) : (s1_tready === 1'b1);
                @(posedge clk); #1;
                if (!rdy) begin
                    waitCnt++;
                    if (waitCnt > 300) begin
                        checkCount++;
                        $display("[TB] FAIL send_timeout ch%0d beat%0d: tready stayed 0, required 1 within 300 cycles", ch, i);
                        dropValid(ch);
                        return;
                    end
                end
            end
        end
        dropValid(ch);
    endtask

    task automatic waitDrain();
        int n = 0;
        @(negedge clk);
        while (idle !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (idle !== 1'b1) begin
            checkCount++;
            $display("[TB] FAIL drain_timeout: idle=%0b, required 1 within 50 cycles", idle);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkCount++;
        if ({m_tvalid, m_tlast, m_tdata} !== 10'h000) $display("[TB] FAIL reset_out: got v=%0b l=%0b d=%02h, required 0/0/00", m_tvalid, m_tlast, m_tdata);
        else passCount++;
        checkCount++;
        if (grant !== 2'b00) $display("[TB] FAIL reset_grant: got %b, required 00", grant);
        else passCount++;
        checkCount++;
        if (idle !== 1'b1) $display("[TB] FAIL reset_idle: got %0b, required 1", idle);
        else passCount++;
        checkCount++;
        if ({s0_tready, s1_tready} !== 2'b00) $display("[TB] FAIL reset_tready: got %b, required 00", {s0_tready, s1_tready});
        else passCount++;
        checkCount++;
        if ({pkt_cnt0, pkt_cnt1} !== 4'b0000) $display("[TB] FAIL reset_cnt: got %0d/%0d, required 0/0", pkt_cnt0, pkt_cnt1);
        else passCount++;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_single_packet();
        logic [7:0] pkt [8];
        pkt = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h00, 8'h00, 8'h00, 8'h00};
        fork
            sendPkt(0, pkt, 4, 1'b1);
            begin
                @(negedge clk);
                checkCount++;
                if (grant !== 2'b00) $display("[TB] FAIL single_grant_idle: got %b, required 00", grant);
                else passCount++;
                @(negedge clk);
                checkCount++;
                if ({grant, s0_tready, m_tvalid} !== 4'b0100) $display("[TB] FAIL single_arb_cycle: got grant=%b rdy=%0b v=%0b, required 01/0/0", grant, s0_tready, m_tvalid);
                else passCount++;
                @(negedge clk);
                checkCount++;
                if ({s0_tready, m_tvalid} !== 2'b10) $display("[TB] FAIL single_lock_cycle: got rdy=%0b v=%0b, required 1/0", s0_tready, m_tvalid);
                else passCount++;
                for (int k = 0; k < 4; k++) begin
                    @(negedge clk);
                    checkCount++;
                    if (m_tvalid !== 1'b1) $display("[TB] FAIL single_stream_beat%0d: m_tvalid=%0b, required 1", k, m_tvalid);
                    else passCount++;
                end
            end
        join
        waitDrain();
        checkCount++;
        if (pkt_cnt0 !== 2'd1) $display("[TB] FAIL single_cnt0: got %0d, required 1", pkt_cnt0);
        else passCount++;
        checkCount++;
        if (idle !== 1'b1) $display("[TB] FAIL single_idle: got %0b, required 1", idle);
        else passCount++;
    endtask

    task automatic test_backpressure();
        logic [7:0] pkt [8];
        bit pat [4];
        bit prevStall;
        logic [7:0] prevData;
        logic prevLast;
        pkt = '{8'hC1, 8'hC2, 8'hC3, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        pat = '{1'b1, 1'b0, 1'b0, 1'b1};
        prevStall = 1'b0;
        prevData  = 8'h00;
        prevLast  = 1'b0;
        fork
            sendPkt(1, pkt, 3, 1'b1);
            begin
                for (int c = 0; c < 14; c++) begin
                    @(posedge clk); #1;
                    m_tready = pat[c % 4];
                    @(negedge clk);
                    if (prevStall) begin
                        checkCount++;
                        if ({m_tvalid, m_tlast, m_tdata} !== {1'b1, prevLast, prevData})
                            $display("[TB] FAIL bp_hold: got v=%0b l=%0b d=%02h, required 1/%0b/%02h", m_tvalid, m_tlast, m_tdata, prevLast, prevData);
                        else passCount++;
                    end
                    prevStall = (m_tvalid === 1'b1) && (m_tready === 1'b0);
                    if (prevStall) begin
                        prevData = m_tdata;
                        prevLast = m_tlast;
                        checkCount++;
                        if (s1_tready !== 1'b0) $display("[TB] FAIL bp_tready: got %0b while output full and stalled, required 0", s1_tready);
                        else passCount++;
                    end
                end
                m_tready = 1'b1;
            end
        join
        waitDrain();
        checkCount++;
        if (pkt_cnt1 !== 2'd1) $display("[TB] FAIL bp_cnt1: got %0d, required 1", pkt_cnt1);
        else passCount++;
    endtask

    task automatic test_lock_integrity();
        logic [7:0] pa [8];
        logic [7:0] pb [8];
        bit done;
        pa = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h00, 8'h00, 8'h00};
        pb = '{8'hE1, 8'hE2, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        done = 1'b0;
        fork
            sendPkt(0, pa, 5, 1'b1);
            begin
                repeat (3) @(posedge clk);
                #1;
                sendPkt(1, pb, 2, 1'b1);
            end
            begin
                for (int c = 0; c < 100 && !done; c++) begin
                    @(negedge clk);
                    checkCount++;
                    if (s1_tready !== 1'b0) $display("[TB] FAIL lock_s1_tready: got %0b during s0 packet, required 0", s1_tready);
                    else passCount++;
                    if (s0_tvalid === 1'b1 && s0_tlast === 1'b1 && s0_tready === 1'b1) done = 1'b1;
                end
                if (!done) begin
                    checkCount++;
                    $display("[TB] FAIL lock_timeout: s0 tlast not accepted, required within 100 cycles");
                end
                for (int b = 0; b < 3; b++) begin
                    @(negedge clk);
                    checkCount++;
                    if (s1_tready !== (b == 2)) $display("[TB] FAIL lock_bubble%0d: s1_tready=%0b, required %0b", b, s1_tready, (b == 2));
                    else passCount++;
                end
            end
        join
        waitDrain();
        checkCount++;
        if ({pkt_cnt0, pkt_cnt1} !== {2'd2, 2'd2}) $display("[TB] FAIL lock_cnt: got %0d/%0d, required 2/2", pkt_cnt0, pkt_cnt1);
        else passCount++;
    endtask

    task automatic test_tie();
        logic [7:0] pa [8];
        logic [7:0] pb [8];
        pa = '{8'hA0, 8'hA1, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        pb = '{8'hB0, 8'hB1, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
`ifdef AES_ARB_RR_EN
        // Alternation starting with s0: A B A B A.
        for (int p = 0; p < 5; p++) begin
            if (p % 2 == 0) begin sbQ.push_back({1'b0, 8'hA0}); sbQ.push_back({1'b1, 8'hA1}); end
            else            begin sbQ.push_back({1'b0, 8'hB0}); sbQ.push_back({1'b1, 8'hB1}); end
        end
`else
        // s0 stays valid, so every A packet goes first: A A A B B.
        for (int p = 0; p < 3; p++) begin sbQ.push_back({1'b0, 8'hA0}); sbQ.push_back({1'b1, 8'hA1}); end
        for (int p = 0; p < 2; p++) begin sbQ.push_back({1'b0, 8'hB0}); sbQ.push_back({1'b1, 8'hB1}); end
`endif
        fork
            begin for (int p = 0; p < 3; p++) sendPkt(0, pa, 2, 1'b0); end
            begin for (int p = 0; p < 2; p++) sendPkt(1, pb, 2, 1'b0); end
        join
        waitDrain();
        checkCount++;
        if ({pkt_cnt0, pkt_cnt1} !== {2'd3, 2'd3}) $display("[TB] FAIL tie_cnt_sat: got %0d/%0d, required 3/3", pkt_cnt0, pkt_cnt1);
        else passCount++;
    endtask

    task automatic test_reset_mid_packet();
        logic [7:0] pb [8];
        int acc;
        bit rdy;
        pb = '{8'hD1, 8'hD2, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        sbQ.push_back({1'b0, 8'h51});
        sbQ.push_back({1'b0, 8'h52});
        s0_tdata = 8'h51; s0_tlast = 1'b0; s0_tvalid = 1'b1;
        acc = 0;
        for (int c = 0; c < 40 && acc < 2; c++) begin
            @(negedge clk);
            rdy = (s0_tready === 1'b1);
            @(posedge clk); #1;
            if (rdy) begin
                acc++;
                s0_tdata = (acc == 1) ? 8'h52 : 8'h53;
            end
        end
        if (acc < 2) begin
            checkCount++;
            $display("[TB] FAIL rstmid_timeout: accepted %0d beats, required 2", acc);
        end
        rst_n = 1'b0;
        @(posedge clk); #1;
        checkCount++;
        if ({m_tvalid, m_tdata} !== 9'h000) $display("[TB] FAIL rstmid_out: got v=%0b d=%02h, required 0/00", m_tvalid, m_tdata);
        else passCount++;
        checkCount++;
        if ({grant, idle, s0_tready} !== 4'b0010) $display("[TB] FAIL rstmid_ctrl: got grant=%b idle=%0b rdy=%0b, required 00/1/0", grant, idle, s0_tready);
        else passCount++;
        checkCount++;
        if ({pkt_cnt0, pkt_cnt1} !== 4'b0000) $display("[TB] FAIL rstmid_cnt: got %0d/%0d, required 0/0", pkt_cnt0, pkt_cnt1);
        else passCount++;
        dropValid(0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        checkCount++;
        if (sbQ.size() !== 0) $display("[TB] FAIL rstmid_dropped: %0d expected beats still pending, required 0", sbQ.size());
        else passCount++;
        sendPkt(1, pb, 2, 1'b1);
        waitDrain();
        checkCount++;
        if ({pkt_cnt0, pkt_cnt1} !== {2'd0, 2'd1}) $display("[TB] FAIL rstmid_after_cnt: got %0d/%0d, required 0/1", pkt_cnt0, pkt_cnt1);
        else passCount++;
    endtask

    task automatic test_counter_sat_clear();
        logic [7:0] pk [8];
        bit done;
        int exp;
        pk = '{8'h90, 8'h91, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        for (int p = 0; p < 5; p++) begin
            sendPkt(0, pk, 2, 1'b1);
            exp = (p + 1 > 3) ? 3 : p + 1;
            checkCount++;
            if (pkt_cnt0 !== exp[CNT_W-1:0]) $display("[TB] FAIL sat_cnt0_p%0d: got %0d, required %0d", p, pkt_cnt0, exp);
            else passCount++;
        end
        waitDrain();
        // One-byte packet whose tlast acceptance coincides with cnt_clr.
        sbQ.push_back({1'b1, 8'h77});
        s0_tdata = 8'h77; s0_tlast = 1'b1; s0_tvalid = 1'b1;
        done = 1'b0;
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge clk);
            if (s0_tready === 1'b1) begin
                cnt_clr = 1'b1;
                done    = 1'b1;
            end
            @(posedge clk); #1;
        end
        cnt_clr = 1'b0;
        dropValid(0);
        if (!done) begin
            checkCount++;
            $display("[TB] FAIL clr_timeout: tlast beat not accepted, required within 40 cycles");
        end
        checkCount++;
        if ({pkt_cnt0, pkt_cnt1} !== 4'b0000) $display("[TB] FAIL clr_cnt: got %0d/%0d, required 0/0", pkt_cnt0, pkt_cnt1);
        else passCount++;
        waitDrain();
        sendPkt(0, pk, 2, 1'b1);
        checkCount++;
        if (pkt_cnt0 !== 2'd1) $display("[TB] FAIL clr_then_inc: got %0d, required 1", pkt_cnt0);
        else passCount++;
        waitDrain();
    endtask

    initial begin
        rst_n     = 1'b0;
        cnt_clr   = 1'b0;
        m_tready  = 1'b1;
        s0_tdata  = 8'h00; s0_tvalid = 1'b0; s0_tlast = 1'b0;
        s1_tdata  = 8'h00; s1_tvalid = 1'b0; s1_tlast = 1'b0;
        @(posedge clk); #1;

        test_reset();
        test_single_packet();
        test_backpressure();
        test_lock_integrity();
        test_tie();
        test_reset_mid_packet();
        test_counter_sat_clear();

        checkCount++;
        if (sbQ.size() !== 0) $display("[TB] FAIL sb_empty: %0d expected beats never appeared, required 0", sbQ.size());
        else passCount++;

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
